// File: rtl/osd_multi_region_overlay.sv
// Multi-region text overlay for a mono video stream: per-frame shadowed region config,
// glyph fetch from a shared 1-cycle font ROM, and a fixed 3-stage blend pipeline to RGB.
module osd_multi_region_overlay #(
  parameter int N_REGIONS     = 4,
  parameter int STRING_LENGTH = 8,
  parameter int CHAR_ENCODING = 12,
  parameter int LAST_CHAR     = 383,
  parameter int CHAR_W        = 8,
  parameter int CHAR_H        = 16,
  parameter int MSB_BPP       = 8,
  parameter int DATA_WIDTH    = 24,
  parameter int FRAME_W       = 640,
  parameter int FRAME_H       = 480,
  localparam int XW  = $clog2(FRAME_W),
  localparam int YW  = $clog2(FRAME_H),
  localparam int FAW = $clog2((LAST_CHAR - 31) * CHAR_W * CHAR_H)
) (
  input  logic                                          pix_clk,
  input  logic                                          rst_n,
  input  logic                                          fval,
  input  logic                                          lval,
  input  logic                                          dval,
  input  logic [MSB_BPP-1:0]                            pix_data,
  input  logic [N_REGIONS-1:0]                          region_en,
  input  logic [2*N_REGIONS-1:0]                        region_mode,
  input  logic [N_REGIONS*XW-1:0]                       region_x,
  input  logic [N_REGIONS*YW-1:0]                       region_y,
  input  logic [N_REGIONS*STRING_LENGTH*CHAR_ENCODING-1:0] region_str,
  input  logic [N_REGIONS*DATA_WIDTH-1:0]               region_color,
  input  logic [DATA_WIDTH-1:0]                         bg_color,
  output logic [FAW-1:0]                                font_addr,
  input  logic [MSB_BPP-1:0]                            font_data,
  output logic [DATA_WIDTH-1:0]                         pix_modified,
  output logic                                          fval_out,
  output logic                                          lval_out,
  output logic                                          dval_out,
  output logic                                          cfg_latched
);
  localparam int CWB = $clog2(CHAR_W);
  localparam int CHB = $clog2(CHAR_H);
  localparam int CIB = $clog2(STRING_LENGTH);
  localparam int CHW = DATA_WIDTH / 3;
  localparam logic [XW:0] BOX_W = (XW+1)'(STRING_LENGTH * CHAR_W);
  localparam logic [YW:0] BOX_H = (YW+1)'(CHAR_H);
  localparam logic [XW-1:0] X_MAX = XW'(FRAME_W - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(FRAME_H - 1);
  localparam logic [CHAR_ENCODING-1:0] CODE_MIN = CHAR_ENCODING'(32);
  localparam logic [CHAR_ENCODING-1:0] CODE_MAX = CHAR_ENCODING'(LAST_CHAR);

  logic [N_REGIONS-1:0]                          sh_en_r;
  logic [2*N_REGIONS-1:0]                        sh_mode_r;
  logic [N_REGIONS*XW-1:0]                       sh_x_r;
  logic [N_REGIONS*YW-1:0]                       sh_y_r;
  logic [N_REGIONS*STRING_LENGTH*CHAR_ENCODING-1:0] sh_str_r;
  logic [N_REGIONS*DATA_WIDTH-1:0]               sh_color_r;
  logic [DATA_WIDTH-1:0]                         sh_bg_r;
  logic [XW-1:0] x_r;
  logic [YW-1:0] y_r;
  logic          fval_d_r, lval_d_r, armed_r, cfg_latched_r;

  logic                     hit_s, gvalid_s;
  logic [1:0]               mode_s;
  logic [DATA_WIDTH-1:0]    color_s;
  logic [FAW-1:0]           addr_s;
  logic [XW-1:0]            rx_s;
  logic [YW-1:0]            ry_s;
  logic [XW:0]              dx_s;
  logic [YW:0]              dy_s;
  logic [CIB-1:0]           cidx_s;
  logic [CHAR_ENCODING-1:0] code_s;

  logic                  s1_hit_r, s1_gvalid_r, s2_hit_r, s2_gvalid_r;
  logic [1:0]            s1_mode_r, s2_mode_r;
  logic [DATA_WIDTH-1:0] s1_color_r, s2_color_r, s1_bg_r, s2_bg_r, pix_r;
  logic [MSB_BPP-1:0]    s1_video_r, s2_video_r;
  logic [2:0]            s1_flags_r, s2_flags_r, flags_out_r;
  logic [FAW-1:0]        font_addr_r;
  logic [MSB_BPP-1:0]    glyph_s;

  function automatic logic [FAW-1:0] glyph_addr(input logic [CHAR_ENCODING-1:0] code,
                                                input logic [CHB-1:0] row,
                                                input logic [CWB-1:0] col);
    logic [CHAR_ENCODING-1:0] off;
    off = code - CODE_MIN;
    glyph_addr = FAW'({off, row, col});
  endfunction

  function automatic logic [CHW-1:0] blend_ch(input logic [1:0] mode, input logic [7:0] g,
                                              input logic [CHW-1:0] c, input logic [CHW-1:0] v,
                                              input logic [CHW-1:0] b);
    logic [15:0] acc;
    acc = 16'd0;
    case (mode)
      2'd1:    blend_ch = (g >= 8'd128) ? c : v;
      2'd2:    blend_ch = (g >= 8'd128) ? c : b;
      2'd3: begin
        acc      = 16'(g) * 16'(c) + 16'(8'd255 - g) * 16'(v);
        blend_ch = CHW'(acc >> 8);
      end
      default: blend_ch = v;
    endcase
  endfunction

  // Frame/line counters and per-frame shadow configuration capture
  always_ff @(posedge pix_clk) begin
    if (!rst_n) begin
      x_r <= {XW{1'b0}};
      y_r <= {YW{1'b0}};
      fval_d_r <= 1'b1;  // a reset inside an active frame must not look like a frame start
      lval_d_r <= 1'b0;
      armed_r <= 1'b0;
      cfg_latched_r <= 1'b0;
      sh_en_r <= {N_REGIONS{1'b0}};
      sh_mode_r <= {(2*N_REGIONS){1'b0}};
      sh_x_r <= {(N_REGIONS*XW){1'b0}};
      sh_y_r <= {(N_REGIONS*YW){1'b0}};
      sh_str_r <= {(N_REGIONS*STRING_LENGTH*CHAR_ENCODING){1'b0}};
      sh_color_r <= {(N_REGIONS*DATA_WIDTH){1'b0}};
      sh_bg_r <= {DATA_WIDTH{1'b0}};
    end else begin
      fval_d_r <= fval;
      lval_d_r <= lval;
      if (!lval) x_r <= {XW{1'b0}};
      else if (dval && (x_r != X_MAX)) x_r <= x_r + XW'(1'b1);
      else x_r <= x_r;
      if (!fval) y_r <= {YW{1'b0}};
      else if (lval_d_r && !lval && (y_r != Y_MAX)) y_r <= y_r + YW'(1'b1);
      else y_r <= y_r;
      if (fval && !fval_d_r) begin
        sh_en_r <= region_en;
        sh_mode_r <= region_mode;
        sh_x_r <= region_x;
        sh_y_r <= region_y;
        sh_str_r <= region_str;
        sh_color_r <= region_color;
        sh_bg_r <= bg_color;
        armed_r <= 1'b1;
        cfg_latched_r <= 1'b1;
      end else begin
        cfg_latched_r <= 1'b0;
      end
    end
  end

  // Region hit search; iterating downwards lets the lowest index win
  always_comb begin
    hit_s = 1'b0;
    gvalid_s = 1'b0;
    mode_s = 2'd0;
    color_s = {DATA_WIDTH{1'b0}};
    addr_s = font_addr_r;
    rx_s = {XW{1'b0}};
    ry_s = {YW{1'b0}};
    dx_s = {(XW+1){1'b0}};
    dy_s = {(YW+1){1'b0}};
    cidx_s = {CIB{1'b0}};
    code_s = {CHAR_ENCODING{1'b0}};
    for (int r = N_REGIONS - 1; r >= 0; r--) begin
      rx_s = sh_x_r[r*XW +: XW];
      ry_s = sh_y_r[r*YW +: YW];
      dx_s = {1'b0, x_r} - {1'b0, rx_s};
      dy_s = {1'b0, y_r} - {1'b0, ry_s};
      cidx_s = dx_s[CWB +: CIB];
      code_s = sh_str_r[(r*STRING_LENGTH + int'(cidx_s))*CHAR_ENCODING +: CHAR_ENCODING];
      if (sh_en_r[r] && (sh_mode_r[2*r +: 2] != 2'd0) && (x_r >= rx_s) && (dx_s < BOX_W)
          && (y_r >= ry_s) && (dy_s < BOX_H)) begin
        hit_s = 1'b1;
        mode_s = sh_mode_r[2*r +: 2];
        color_s = sh_color_r[r*DATA_WIDTH +: DATA_WIDTH];
        gvalid_s = (code_s >= CODE_MIN) && (code_s <= CODE_MAX);
        if (gvalid_s) addr_s = glyph_addr(code_s, dy_s[CHB-1:0], dx_s[CWB-1:0]);
        else addr_s = font_addr_r;
      end else begin
        hit_s = hit_s;
      end
    end
    if (!(armed_r && lval && dval)) begin
      hit_s = 1'b0;
      gvalid_s = 1'b0;
      addr_s = font_addr_r;
    end else begin
      hit_s = hit_s;
    end
  end

  assign glyph_s = s2_gvalid_r ? font_data : {MSB_BPP{1'b0}};

  // S1 capture, S2 wait for ROM, S3 blend; flags ride alongside so latency is fixed
  always_ff @(posedge pix_clk) begin
    if (!rst_n) begin
      {s1_hit_r, s1_gvalid_r, s2_hit_r, s2_gvalid_r} <= 4'b0000;
      s1_mode_r <= 2'd0;
      s2_mode_r <= 2'd0;
      s1_color_r <= {DATA_WIDTH{1'b0}};
      s2_color_r <= {DATA_WIDTH{1'b0}};
      s1_bg_r <= {DATA_WIDTH{1'b0}};
      s2_bg_r <= {DATA_WIDTH{1'b0}};
      s1_video_r <= {MSB_BPP{1'b0}};
      s2_video_r <= {MSB_BPP{1'b0}};
      s1_flags_r <= 3'b000;
      s2_flags_r <= 3'b000;
      flags_out_r <= 3'b000;
      font_addr_r <= {FAW{1'b0}};
      pix_r <= {DATA_WIDTH{1'b0}};
    end else begin
      s1_hit_r <= hit_s;
      s1_gvalid_r <= gvalid_s;
      s1_mode_r <= mode_s;
      s1_color_r <= color_s;
      s1_bg_r <= sh_bg_r;
      s1_video_r <= pix_data;
      s1_flags_r <= {fval, lval, dval};
      font_addr_r <= addr_s;
      s2_hit_r <= s1_hit_r;
      s2_gvalid_r <= s1_gvalid_r;
      s2_mode_r <= s1_mode_r;
      s2_color_r <= s1_color_r;
      s2_bg_r <= s1_bg_r;
      s2_video_r <= s1_video_r;
      s2_flags_r <= s1_flags_r;
      flags_out_r <= s2_flags_r;
      if (s2_hit_r) begin
        pix_r <= {blend_ch(s2_mode_r, glyph_s, s2_color_r[2*CHW +: CHW], s2_video_r, s2_bg_r[2*CHW +: CHW]),
                  blend_ch(s2_mode_r, glyph_s, s2_color_r[CHW +: CHW],   s2_video_r, s2_bg_r[CHW +: CHW]),
                  blend_ch(s2_mode_r, glyph_s, s2_color_r[0 +: CHW],     s2_video_r, s2_bg_r[0 +: CHW])};
      end else begin
        pix_r <= {s2_video_r, s2_video_r, s2_video_r};
      end
    end
  end

  assign font_addr = font_addr_r;
  assign pix_modified = pix_r;
  assign {fval_out, lval_out, dval_out} = flags_out_r;
  assign cfg_latched = cfg_latched_r;
endmodule

// File: tb/tb_osd_multi_region_overlay.sv
// Directed bench for osd_multi_region_overlay: drives short frames, captures output pixels by
// input coordinate (3-cycle lag) and compares selected points against hand-computed values.
module tb_osd_multi_region_overlay;
  localparam int XW = 10;
  localparam int YW = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0, fval = 1'b0, lval = 1'b0, dval = 1'b0;
  logic [7:0] pix_data = 8'd0;
  logic [3:0] region_en = 4'd0;
  logic [7:0] region_mode = 8'd0;
  logic [39:0] region_x = 40'd0;
  logic [35:0] region_y = 36'd0;
  logic [383:0] region_str = 384'd0;
  logic [95:0] region_color = 96'd0;
  logic [23:0] bg_color = 24'd0;
  logic [15:0] font_addr;
  logic [7:0] font_data;
  logic [23:0] pix_modified;
  logic fval_out, lval_out, dval_out, cfg_latched;
  logic [7:0] rom_val = 8'd0;

  osd_multi_region_overlay dut (
    .pix_clk(clk), .rst_n(rst_n), .fval(fval), .lval(lval), .dval(dval), .pix_data(pix_data),
    .region_en(region_en), .region_mode(region_mode), .region_x(region_x), .region_y(region_y),
    .region_str(region_str), .region_color(region_color), .bg_color(bg_color),
    .font_addr(font_addr), .font_data(font_data), .pix_modified(pix_modified),
    .fval_out(fval_out), .lval_out(lval_out), .dval_out(dval_out), .cfg_latched(cfg_latched));

  // font ROM model: one cycle of read latency, content selected per test
  always @(posedge clk) font_data <= rom_val;

  int errors = 0, checks = 0;
  logic [23:0] cap [int];
  logic [15:0] addr_cap [int];
  int hk [3] = '{-1, -1, -1};
  logic [2:0] hf [3] = '{3'b000, 3'b000, 3'b000};
  int lag_err = 0, cfg_count = 0, rst_cnt = 0, rst_line = -1;
  bit apply_mid = 1'b0, use_fixed = 1'b0;
  logic [3:0] en_mid = 4'd0;
  logic [7:0] vid_fixed = 8'd0;

  localparam logic [23:0] RED = 24'hFF0000, GREEN = 24'h00FF00, BLUE = 24'h0000FF;

  function automatic int key(int x, int y);
    return y * 1024 + x;
  endfunction
  function automatic logic [7:0] vid(int x, int y);
    if (use_fixed) return vid_fixed;
    return 8'((x + 3 * y) % 256);
  endfunction
  function automatic logic [23:0] gray(int x, int y);
    logic [7:0] v;
    v = vid(x, y);
    return {v, v, v};
  endfunction
  function automatic logic [23:0] cap_at(int x, int y);
    if (cap.exists(key(x, y))) return cap[key(x, y)];
    return 24'hxxxxxx;
  endfunction
  function automatic logic [15:0] addr_at(int x, int y);
    if (addr_cap.exists(key(x, y))) return addr_cap[key(x, y)];
    return 16'hxxxx;
  endfunction
  function automatic logic [95:0] str3(int c0, int c1, int c2);
    logic [95:0] s;
    s = 96'd0;
    s[11:0] = 12'(c0);
    s[23:12] = 12'(c1);
    s[35:24] = 12'(c2);
    return s;
  endfunction

  task automatic set_region(input int r, input logic en, input logic [1:0] mode, input int x,
                            input int y, input logic [95:0] s, input logic [23:0] col);
    region_en[r] = en;
    region_mode[2*r +: 2] = mode;
    region_x[r*XW +: XW] = XW'(x);
    region_y[r*YW +: YW] = YW'(y);
    region_str[r*96 +: 96] = s;
    region_color[r*24 +: 24] = col;
  endtask

  task automatic clear_regions();
    for (int r = 0; r < 4; r++) set_region(r, 1'b0, 2'd0, 0, 0, 96'd0, 24'd0);
  endtask

  task automatic step(input logic f, input logic l, input logic d, input int k, input logic [7:0] v);
    @(negedge clk);
    fval = f; lval = l; dval = d; pix_data = v;
    if (rst_cnt > 0) begin
      rst_n = 1'b0;
      rst_cnt--;
    end else begin
      rst_n = 1'b1;
    end
    @(posedge clk);
    #1;
    if (!rst_n) begin
      checks++;
      if (pix_modified !== 24'd0 || {fval_out, lval_out, dval_out} !== 3'b000 ||
          cfg_latched !== 1'b0 || font_addr !== 16'd0) begin
        errors++;
        $display("FAIL reset_outputs: got pix=%h flags=%b cfg=%b addr=%h, required all zero",
                 pix_modified, {fval_out, lval_out, dval_out}, cfg_latched, font_addr);
      end
      hk = '{-1, -1, -1};
      hf = '{3'b000, 3'b000, 3'b000};
    end else begin
      hk[2] = hk[1]; hk[1] = hk[0]; hk[0] = k;
      hf[2] = hf[1]; hf[1] = hf[0]; hf[0] = {f, l, d};
      if ({fval_out, lval_out, dval_out} !== hf[2]) lag_err++;
      if (hk[2] >= 0) cap[hk[2]] = pix_modified;
      if (k >= 0) addr_cap[k] = font_addr;
      if (cfg_latched === 1'b1) cfg_count++;
    end
  endtask

  task automatic drive_frame(input int lines, input int pix, input int short_until);
    int np;
    cap.delete();
    addr_cap.delete();
    lag_err = 0;
    cfg_count = 0;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, -1, 8'd0);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b0, -1, 8'd0);
    for (int y = 0; y < lines; y++) begin
      np = (y < short_until) ? 1 : pix;
      for (int x = 0; x < np; x++) begin
        if (apply_mid && y == 1 && x == 0) region_en = en_mid;
        if (y == rst_line && x == 5) rst_cnt = 2;
        step(1'b1, 1'b1, 1'b1, key(x, y), vid(x, y));
      end
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, -1, 8'd0);
    end
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, -1, 8'd0);
    checks++;
    if (lag_err != 0) begin
      errors++;
      $display("FAIL flag_lag: got %0d cycles with wrong delayed flags, required 0", lag_err);
    end
  endtask

  task automatic test_reset();
    rst_cnt = 4;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, -1, 8'h5A);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0, -1, 8'd0);
    checks++;
    if (pix_modified !== 24'd0 || cfg_latched !== 1'b0 || font_addr !== 16'd0) begin
      errors++;
      $display("FAIL idle_after_reset: got pix=%h cfg=%b addr=%h, required 0/0/0",
               pix_modified, cfg_latched, font_addr);
    end
  endtask

  task automatic test_mid_reset();
    clear_regions();
    set_region(0, 1'b1, 2'd1, 0, 8, str3(65, 66, 0), RED);
    rom_val = 8'd255;
    rst_line = 10;
    drive_frame(14, 20, 0);
    rst_line = -1;
    checks++;
    if (cap_at(0, 9) !== RED) begin
      errors++; $display("FAIL pre_reset_px: got %h required %h", cap_at(0, 9), RED);
    end
    checks++;
    if (cap_at(10, 10) !== gray(10, 10)) begin
      errors++; $display("FAIL passthru_10_10: got %h required %h", cap_at(10, 10), gray(10, 10));
    end
    checks++;
    if (cap_at(3, 13) !== gray(3, 13)) begin
      errors++; $display("FAIL passthru_3_13: got %h required %h", cap_at(3, 13), gray(3, 13));
    end
    drive_frame(14, 20, 0);
    checks++;
    if (cfg_count !== 1) begin
      errors++; $display("FAIL cfg_pulse_rearm: got %0d pulses required 1", cfg_count);
    end
    checks++;
    if (cap_at(10, 12) !== RED) begin
      errors++; $display("FAIL rearmed_px: got %h required %h", cap_at(10, 12), RED);
    end
  endtask

  task automatic test_single_region();
    int px [7] = '{100, 115, 107, 99, 116, 100, 100};
    int py [7] = '{50, 65, 57, 50, 50, 49, 66};
    bit red [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    int ax [3] = '{100, 108, 115};
    int ay [3] = '{50, 51, 65};
    logic [15:0] aexp [3] = '{16'd4224, 16'd4360, 16'd4479};
    logic [23:0] e;
    clear_regions();
    set_region(0, 1'b1, 2'd1, 100, 50, str3(65, 66, 0), RED);
    rom_val = 8'd255;
    use_fixed = 1'b0;
    drive_frame(67, 120, 49);
    checks++;
    if (cfg_count !== 1) begin
      errors++; $display("FAIL cfg_pulse: got %0d pulses required 1", cfg_count);
    end
    for (int i = 0; i < 7; i++) begin
      e = red[i] ? RED : gray(px[i], py[i]);
      checks++;
      if (cap_at(px[i], py[i]) !== e) begin
        errors++;
        $display("FAIL key_px (%0d,%0d): got %h required %h", px[i], py[i], cap_at(px[i], py[i]), e);
      end
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (addr_at(ax[i], ay[i]) !== aexp[i]) begin
        errors++;
        $display("FAIL font_addr (%0d,%0d): got %0d required %0d", ax[i], ay[i], addr_at(ax[i], ay[i]), aexp[i]);
      end
    end
  endtask

  task automatic test_overlap();
    logic [23:0] e;
    clear_regions();
    set_region(0, 1'b1, 2'd1, 200, 100, str3(65, 0, 0), GREEN);
    set_region(1, 1'b1, 2'd1, 200, 100, str3(65, 0, 0), BLUE);
    rom_val = 8'd255;
    en_mid = 4'b0010;
    for (int f = 0; f < 3; f++) begin
      apply_mid = (f == 1);
      drive_frame(101, 210, 100);
      e = (f == 2) ? BLUE : GREEN;
      checks++;
      if (cap_at(200, 100) !== e) begin
        errors++; $display("FAIL overlap_f%0d (200,100): got %h required %h", f, cap_at(200, 100), e);
      end
      checks++;
      if (cap_at(207, 100) !== e) begin
        errors++; $display("FAIL overlap_f%0d (207,100): got %h required %h", f, cap_at(207, 100), e);
      end
    end
    apply_mid = 1'b0;
  endtask

  task automatic test_blend();
    clear_regions();
    set_region(0, 1'b1, 2'd3, 0, 2, str3(65, 0, 0), 24'hFF0080);
    use_fixed = 1'b1;
    vid_fixed = 8'h00;
    rom_val = 8'd128;
    drive_frame(3, 10, 0);
    checks++;
    if (cap_at(0, 2) !== 24'h7F0040) begin
      errors++; $display("FAIL blend_g128: got %h required 7f0040", cap_at(0, 2));
    end
    rom_val = 8'd0;
    drive_frame(3, 10, 0);
    checks++;
    if (cap_at(7, 2) !== 24'h000000) begin
      errors++; $display("FAIL blend_g0: got %h required 000000", cap_at(7, 2));
    end
    vid_fixed = 8'h40;
    rom_val = 8'd64;
    drive_frame(3, 10, 0);
    checks++;
    if (cap_at(3, 2) !== 24'h6F2F4F) begin
      errors++; $display("FAIL blend_g64: got %h required 6f2f4f", cap_at(3, 2));
    end
    checks++;
    if (cap_at(3, 1) !== 24'h404040) begin
      errors++; $display("FAIL blend_outside: got %h required 404040", cap_at(3, 1));
    end
    use_fixed = 1'b0;
  endtask

  task automatic test_box();
    int px [6] = '{4, 12, 20, 67, 3, 68};
    bit inb [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    int ax [4] = '{11, 12, 19, 20};
    logic [15:0] aexp [4] = '{16'd4231, 16'd4231, 16'd4231, 16'd4352};
    logic [23:0] e;
    clear_regions();
    set_region(0, 1'b1, 2'd2, 4, 1, str3(65, 16, 66), 24'hFFFFFF);
    bg_color = 24'h102030;
    rom_val = 8'd0;
    drive_frame(2, 72, 0);
    for (int i = 0; i < 6; i++) begin
      e = inb[i] ? 24'h102030 : gray(px[i], 1);
      checks++;
      if (cap_at(px[i], 1) !== e) begin
        errors++; $display("FAIL box_px (%0d,1): got %h required %h", px[i], cap_at(px[i], 1), e);
      end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (addr_at(ax[i], 1) !== aexp[i]) begin
        errors++; $display("FAIL box_addr (%0d,1): got %0d required %0d", ax[i], addr_at(ax[i], 1), aexp[i]);
      end
    end
    rom_val = 8'd255;
    drive_frame(2, 72, 0);
    checks++;
    if (cap_at(11, 1) !== 24'hFFFFFF) begin
      errors++; $display("FAIL box_glyph: got %h required ffffff", cap_at(11, 1));
    end
    checks++;
    if (cap_at(12, 1) !== 24'h102030) begin
      errors++; $display("FAIL box_badcode: got %h required 102030", cap_at(12, 1));
    end
  endtask

  task automatic test_right_edge();
    int px [6] = '{635, 636, 639, 0, 3, 636};
    int py [6] = '{0, 0, 0, 1, 1, 1};
    bit red [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [23:0] e;
    clear_regions();
    set_region(0, 1'b1, 2'd1, 636, 0, str3(65, 65, 0), RED);
    rom_val = 8'd255;
    drive_frame(2, 640, 0);
    for (int i = 0; i < 6; i++) begin
      e = red[i] ? RED : gray(px[i], py[i]);
      checks++;
      if (cap_at(px[i], py[i]) !== e) begin
        errors++;
        $display("FAIL edge_px (%0d,%0d): got %h required %h", px[i], py[i], cap_at(px[i], py[i]), e);
      end
    end
  endtask

  initial begin
    #5000000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_mid_reset();
    test_single_region();
    test_overlap();
    test_blend();
    test_box();
    test_right_edge();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
